command_parser: RTL and testbench
=================================

# command_parser

Frame assembler that sits directly downstream of the character decoder and consumes its decoded character stream (data bytes, start markers, end markers). It collects one command frame, validates its length, and presents a single bus command to the protocol interface through a valid/ready handshake. It flags malformed frames with a one-cycle error pulse and a code. It performs no peripheral access itself.

## Interface
- MAX_DATA, 4: maximum write payload bytes per frame (1..4); sets the cmd_wdata packing limit.

- clk  in  1  module clock (clk_12MHz at top level)
- reset  in  1  asynchronous, active-low reset
- drdy_in  in  1  decoder data-ready; rising edge marks one character event
- data_in  in  8  decoded byte; valid at the drdy_in rising edge
- start_c  in  1  character is a start marker; data_in ignored
- end_c  in  1  character is an end marker; data_in ignored
- cmd_valid  out  1  command fields valid; held until accepted
- cmd_ready  in  1  consumer accepts the command when high with cmd_valid
- cmd_rw  out  1  0 = write, 1 = read
- cmd_periph  out  7  peripheral select index
- cmd_reg  out  8  register address
- cmd_wdata  out  32  write payload, little-endian, unused bytes zero
- cmd_wlen  out  3  payload byte count, 0..MAX_DATA
- frame_error  out  1  one-cycle pulse on a malformed frame
- err_code  out  2  0 SHORT, 1 LONG, 2 ABORT, 3 OVERRUN; valid with frame_error, otherwise holds its last value

## Operation
- Frame format: start, header {rw, periph[6:0]}, reg byte, payload of 0..MAX_DATA bytes (writes only), end.
- Character event: drdy_in & ~drdy_q. drdy_q is a register that resets to 1, so a level that is already high at reset release does not fire an event.
- If start_c and end_c are both set on one event, start_c takes priority.
- States:
  - IDLE: start -> HDR. Data and end are ignored silently.
  - HDR: data -> latch rw/periph, clear wdata/wlen, go to REG. Start -> stay in HDR (ABORT). End -> IDLE (SHORT).
  - REG: data -> latch reg, go to DATA. Start -> HDR (ABORT). End -> IDLE (SHORT).
  - DATA: data with wlen < MAX_DATA and rw = 0 -> wdata byte[wlen] <= data, wlen+1.
  - DATA: data with wlen = MAX_DATA, or with rw = 1 -> IDLE (LONG).
  - DATA: end -> HOLD. Start -> HDR (ABORT).
  - HOLD: cmd_valid = 1. cmd_valid & cmd_ready -> IDLE. Any character event, including start, is discarded (OVERRUN).
- ABORT restarts frame capture; the new header is expected next.
- A read frame with zero payload and a write frame with zero payload are both legal.

## Timing
- Reset values: state IDLE, every output 0, err_code 0, drdy_q 1.
- Event detected in cycle N:
  - state, field and error registers update at edge N+1;
  - frame_error is high for exactly one cycle (N+1).
- End event in cycle N -> cmd_valid high from cycle N+1.
- With cmd_ready already high, acceptance happens in cycle N+1 and cmd_valid is low from N+2.
- cmd_* fields remain stable while cmd_valid is high and change only after acceptance.
- A new frame's start event in the cycle after acceptance is accepted normally.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the partial command is lost and no error pulses.

## Structure
- uniboard_pkg holds:
  - the state enum (IDLE, HDR, REG, DATA, HOLD);
  - the err_code enum;
  - a cmd struct (rw, periph, reg, wdata, wlen).
- Sub-module rising_edge_detect (parameterised reset value) produces the character event; shared with other drdy-driven stages.

## Test plan
- Write frame: start, 0x05, 0x10, 0xAA, 0xBB, end -> cmd_valid with rw 0, periph 5, reg 0x10, wdata 0x0000BBAA, wlen 2; no frame_error.
- Read frame: start, 0x83, 0x02, end with cmd_ready held low for 10 cycles -> cmd_valid held 10 cycles with rw 1, periph 3, wlen 0, wdata 0; fields stable; cmd_valid low one cycle after ready.
- Overlength write: start, 0x01, 0x00, five data bytes -> frame_error with code LONG on the 5th byte; state IDLE; later end ignored; no cmd_valid.
- Malformed frames:
  - start, 0x01, end -> code SHORT;
  - start, 0x01, start, 0x02, 0x07, end -> code ABORT, then a command with periph 2, reg 7.
- HOLD overrun plus reset:
  - a character event during HOLD -> code OVERRUN with the command unchanged;
  - reset asserted during DATA -> all outputs 0 at once, and a full frame after release decodes correctly.

Source files
------------

// File: rtl/uniboard_pkg.sv
// Shared types for the uniboard command path.
// Frame-capture states, error codes and the bus command bundle.
package uniboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG,
        ST_DATA,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        ERR_SHORT   = 2'd0,
        ERR_LONG    = 2'd1,
        ERR_ABORT   = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_t;

    typedef struct packed {
        logic        rw;
        logic [6:0]  periph;
        logic [7:0]  reg_addr;
        logic [31:0] wdata;
        logic [2:0]  wlen;
    } cmd_t;

endpackage

// File: rtl/command_parser_if.sv
// Bus command handshake between the frame parser and the protocol side.
// The parser is master; the consumer answers with cmd_ready.
interface command_parser_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_periph;
    logic [7:0]  cmd_reg;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_wlen;

    modport master (
        output cmd_valid,
        output cmd_rw,
        output cmd_periph,
        output cmd_reg,
        output cmd_wdata,
        output cmd_wlen,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_rw,
        input  cmd_periph,
        input  cmd_reg,
        input  cmd_wdata,
        input  cmd_wlen,
        output cmd_ready
    );

endinterface

// File: rtl/rising_edge_detect.sv
// Single-cycle pulse on a rising level of d.
// RESET_VAL=1 suppresses a level already high at reset release.
module rising_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // previous sample of d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) d_q <= RESET_VAL;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/command_parser.sv
// Frame assembler: decoded characters in, one bus command out.
// Malformed frames raise a one-cycle frame_error with a code.
import uniboard_pkg::*;

module command_parser #(
    parameter int MAX_DATA = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drdy_in,
    input  logic [7:0]       data_in,
    input  logic             start_c,
    input  logic             end_c,
    command_parser_if.master cmd,
    output logic             frame_error,
    output logic [1:0]       err_code
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_DATA);

    state_t state;
    cmd_t   cmd_q;
    logic   valid_q;
    logic   ferr_q;
    err_t   err_q;
    logic   ev;

    rising_edge_detect #(
        .RESET_VAL(1'b1)
    ) u_edge (
        .clk  (clk),
        .reset(reset),
        .d    (drdy_in),
        .rise (ev)
    );

    // frame capture, command hold and error reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            err_q   <= ERR_SHORT;
        end else begin
            ferr_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ev && start_c) state <= ST_HDR;
                end
                ST_HDR: begin
                    if (ev) begin
                        priority case (1'b1)
                            start_c: begin
                                ferr_q <= 1'b1;
                                err_q  <= ERR_ABORT;
                            end
                            end_c: begin
                                ferr_q <= 1'b1;
                                err_q  <= ERR_SHORT;
                                state  <= ST_IDLE;
                            end
                            default: begin
                                cmd_q.rw     <= data_in[7];
                                cmd_q.periph <= data_in[6:0];
                                cmd_q.wdata  <= '0;
                                cmd_q.wlen   <= '0;
                                state        <= ST_REG;
                            end
                        endcase
                    end
                end
                ST_REG: begin
                    if (ev) begin
                        priority case (1'b1)
                            start_c: begin
                                ferr_q <= 1'b1;
                                err_q  <= ERR_ABORT;
                                state  <= ST_HDR;
                            end
                            end_c: begin
                                ferr_q <= 1'b1;
                                err_q  <= ERR_SHORT;
                                state  <= ST_IDLE;
                            end
                            default: begin
                                cmd_q.reg_addr <= data_in;
                                state          <= ST_DATA;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (ev) begin
                        priority case (1'b1)
                            start_c: begin
                                ferr_q <= 1'b1;
                                err_q  <= ERR_ABORT;
                                state  <= ST_HDR;
                            end
                            end_c: begin
                                valid_q <= 1'b1;
                                state   <= ST_HOLD;
                            end
                            default: begin
                                if (cmd_q.rw || cmd_q.wlen >= MAX_LEN) begin
                                    ferr_q <= 1'b1;
                                    err_q  <= ERR_LONG;
                                    state  <= ST_IDLE;
                                end else begin
                                    cmd_q.wdata[{cmd_q.wlen[1:0], 3'b000} +: 8]
                                        <= data_in;
                                    cmd_q.wlen <= cmd_q.wlen + 3'd1;
                                end
                            end
                        endcase
                    end
                end
                ST_HOLD: begin
                    if (ev) begin
                        ferr_q <= 1'b1;
                        err_q  <= ERR_OVERRUN;
                    end
                    if (cmd.cmd_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd.cmd_valid  = valid_q;
    assign cmd.cmd_rw     = cmd_q.rw;
    assign cmd.cmd_periph = cmd_q.periph;
    assign cmd.cmd_reg    = cmd_q.reg_addr;
    assign cmd.cmd_wdata  = cmd_q.wdata;
    assign cmd.cmd_wlen   = cmd_q.wlen;
    assign frame_error    = ferr_q;
    assign err_code       = err_q;

endmodule

// File: tb/tb_command_parser.sv
// Bench for command_parser: directed frames plus random frames
// checked against a frame-level reference model.
module tb_command_parser;

    localparam int MAX_DATA = 4;
    localparam int K_DATA  = 0;
    localparam int K_START = 1;
    localparam int K_END   = 2;
    localparam int K_BOTH  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       drdy_in;
    logic [7:0] data_in;
    logic       start_c;
    logic       end_c;
    logic       frame_error;
    logic [1:0] err_code;

    command_parser_if ifc();

    command_parser #(
        .MAX_DATA(MAX_DATA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .drdy_in    (drdy_in),
        .data_in    (data_in),
        .start_c    (start_c),
        .end_c      (end_c),
        .cmd        (ifc),
        .frame_error(frame_error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state: frame-level view
    bit         in_frame;
    bit         hold;
    bit [1:0]   last_code;
    logic [7:0] fbuf[$];
    bit         m_rw;
    bit [6:0]   m_periph;
    bit [7:0]   m_reg;
    bit [31:0]  m_wdata;
    bit [2:0]   m_wlen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        in_frame  = 0;
        hold      = 0;
        last_code = 0;
        fbuf.delete();
    endtask

    task automatic model_char(input int kind, input logic [7:0] d,
                              output bit err);
        bit [1:0] code;
        err  = 0;
        code = 0;
        if (hold) begin
            err  = 1;
            code = 3;
        end else if (kind == K_START || kind == K_BOTH) begin
            if (in_frame) begin
                err  = 1;
                code = 2;
            end
            in_frame = 1;
            fbuf.delete();
        end else if (!in_frame) begin
            err = 0;
        end else if (kind == K_END) begin
            in_frame = 0;
            if (fbuf.size() < 2) begin
                err  = 1;
                code = 0;
            end else begin
                m_rw     = fbuf[0][7];
                m_periph = fbuf[0][6:0];
                m_reg    = fbuf[1];
                m_wdata  = 0;
                for (int i = 2; i < fbuf.size(); i++)
                    m_wdata[8*(i-2) +: 8] = fbuf[i];
                m_wlen = 3'(fbuf.size() - 2);
                hold   = 1;
            end
        end else begin
            fbuf.push_back(d);
            if (fbuf.size() > 2 &&
                (fbuf[0][7] == 1'b1 || fbuf.size() > 2 + MAX_DATA)) begin
                err      = 1;
                code     = 1;
                in_frame = 0;
            end
        end
        if (err) last_code = code;
    endtask

    task automatic check_cmd();
        check("valid", ifc.cmd_valid, hold);
        if (hold) begin
            check("rw", ifc.cmd_rw, m_rw);
            check("periph", ifc.cmd_periph, m_periph);
            check("reg", ifc.cmd_reg, m_reg);
            check("wdata", ifc.cmd_wdata, m_wdata);
            check("wlen", ifc.cmd_wlen, m_wlen);
        end
    endtask

    task automatic check_zero();
        check("z_valid", ifc.cmd_valid, 0);
        check("z_ferr", frame_error, 0);
        check("z_code", err_code, 0);
        check("z_rw", ifc.cmd_rw, 0);
        check("z_periph", ifc.cmd_periph, 0);
        check("z_reg", ifc.cmd_reg, 0);
        check("z_wdata", ifc.cmd_wdata, 0);
        check("z_wlen", ifc.cmd_wlen, 0);
    endtask

    // called #1 after a posedge with drdy_in low; returns likewise
    task automatic send_char(input int kind, input logic [7:0] d);
        bit e;
        drdy_in = 1;
        start_c = (kind == K_START || kind == K_BOTH);
        end_c   = (kind == K_END || kind == K_BOTH);
        data_in = d;
        model_char(kind, d, e);
        @(posedge clk);
        #1;
        check("ferr", frame_error, e);
        check("ecode", err_code, last_code);
        check_cmd();
        drdy_in = 0;
        start_c = 0;
        end_c   = 0;
        data_in = 0;
        if (hold && ifc.cmd_ready) hold = 0;
        @(posedge clk);
        #1;
        check("ferr_pulse", frame_error, 0);
        check("valid_next", ifc.cmd_valid, hold);
    endtask

    task automatic do_accept();
        ifc.cmd_ready = 1;
        @(posedge clk);
        #1;
        ifc.cmd_ready = 0;
        hold = 0;
        check("accept", ifc.cmd_valid, 0);
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        check_zero();
        model_clear();
        drdy_in = 0;
        start_c = 0;
        end_c   = 0;
        ifc.cmd_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] hdr;

        reset   = 0;
        drdy_in = 1;
        start_c = 1;
        end_c   = 0;
        data_in = 0;
        ifc.cmd_ready = 0;
        model_clear();
        #2;
        check_zero();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        check("rel_ferr", frame_error, 0);
        @(posedge clk);
        #1;
        drdy_in = 0;
        start_c = 0;
        @(posedge clk);
        #1;
        send_char(K_DATA, 8'h01);
        send_char(K_END, 8'h00);

        // write frame
        send_char(K_START, 0);
        send_char(K_DATA, 8'h05);
        send_char(K_DATA, 8'h10);
        send_char(K_DATA, 8'hAA);
        send_char(K_DATA, 8'hBB);
        send_char(K_END, 0);
        check("w_periph", ifc.cmd_periph, 5);
        check("w_reg", ifc.cmd_reg, 8'h10);
        check("w_wdata", ifc.cmd_wdata, 32'h0000BBAA);
        check("w_wlen", ifc.cmd_wlen, 2);
        do_accept();

        // read frame held for 10 cycles
        send_char(K_START, 0);
        send_char(K_DATA, 8'h83);
        send_char(K_DATA, 8'h02);
        send_char(K_END, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("r_hold", ifc.cmd_valid, 1);
            check("r_rw", ifc.cmd_rw, 1);
            check("r_periph", ifc.cmd_periph, 3);
            check("r_wlen", ifc.cmd_wlen, 0);
            check("r_wdata", ifc.cmd_wdata, 0);
        end
        do_accept();

        // overlength write
        send_char(K_START, 0);
        send_char(K_DATA, 8'h01);
        send_char(K_DATA, 8'h00);
        for (int i = 0; i < 5; i++) send_char(K_DATA, 8'(8'h20 + i));
        check("long_code", err_code, 1);
        send_char(K_END, 0);

        // short frame
        send_char(K_START, 0);
        send_char(K_DATA, 8'h01);
        send_char(K_END, 0);
        check("short_code", err_code, 0);

        // abort, with ready already high at end
        send_char(K_START, 0);
        send_char(K_DATA, 8'h01);
        send_char(K_START, 0);
        check("abort_code", err_code, 2);
        send_char(K_DATA, 8'h02);
        send_char(K_DATA, 8'h07);
        ifc.cmd_ready = 1;
        send_char(K_END, 0);
        ifc.cmd_ready = 0;
        send_char(K_START, 0);
        send_char(K_DATA, 8'h04);
        send_char(K_DATA, 8'h20);
        send_char(K_END, 0);
        do_accept();

        // start and end on one event: start wins
        send_char(K_BOTH, 0);
        send_char(K_DATA, 8'h01);
        send_char(K_DATA, 8'h02);
        send_char(K_END, 0);
        do_accept();

        // full-length write, then overrun during hold
        send_char(K_START, 0);
        send_char(K_DATA, 8'h09);
        send_char(K_DATA, 8'h33);
        for (int i = 0; i < MAX_DATA; i++) send_char(K_DATA, 8'(8'h11 * (i + 1)));
        send_char(K_END, 0);
        check("full_wdata", ifc.cmd_wdata, 32'h44332211);
        send_char(K_DATA, 8'h55);
        check("ovr_code", err_code, 3);
        send_char(K_START, 0);
        do_accept();

        // reset mid-data, then a clean frame
        send_char(K_START, 0);
        send_char(K_DATA, 8'h05);
        send_char(K_DATA, 8'h10);
        send_char(K_DATA, 8'hAA);
        do_reset();
        send_char(K_START, 0);
        send_char(K_DATA, 8'h06);
        send_char(K_DATA, 8'h11);
        send_char(K_DATA, 8'h12);
        send_char(K_END, 0);
        check("post_rst_wdata", ifc.cmd_wdata, 32'h12);
        do_accept();

        // reset during hold
        send_char(K_START, 0);
        send_char(K_DATA, 8'h07);
        send_char(K_DATA, 8'h01);
        send_char(K_END, 0);
        do_reset();

        // random frames
        for (int f = 0; f < 80; f++) begin
            send_char(K_START, 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_char(K_END, 0);
            end else begin
                hdr = 8'($urandom);
                if ($urandom_range(0, 2) != 0) hdr[7] = 1'b0;
                send_char(K_DATA, hdr);
                if (r == 1) send_char(K_BOTH, 0);
                if (r == 2) send_char(K_START, 0);
                if (r == 1 || r == 2) send_char(K_DATA, 8'($urandom));
                send_char(K_DATA, 8'($urandom));
                n = (hdr[7] && $urandom_range(0, 2) != 0) ? 0 : $urandom_range(0, 5);
                for (int i = 0; i < n; i++) send_char(K_DATA, 8'($urandom));
                send_char(K_END, 0);
            end
            if ($urandom_range(0, 5) == 0)
                send_char($urandom_range(0, 3), 8'($urandom));
            if (hold) do_accept();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
